muldiv_iter: RTL

Parametrised iterative multiply/divide unit for the EX stage. It replaces the fixed 32-bit divider behind the start/annul/ready handshake and adds shift-add multiplication in the same datapath. It produces a 2*WIDTH result {hi, lo} for the HI/LO path. While busy_o is high, EX holds stallreq_for_ex asserted.

---
 rtl/muldiv_iter_if.sv | 26 ++
 rtl/muldiv_iter.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/muldiv_iter_if.sv
// EX-stage handshake and operand/result bundle for the iterative multiply/divide unit.
// The EX stage drives the master side and the unit implements the slave side.
interface muldiv_iter_if #(
    parameter int WIDTH = 32
);
    logic                   start_i;
    logic                   annul_i;
    logic                   op_div_i;
    logic                   op_signed_i;
    logic [WIDTH-1:0]       opdata1_i;
    logic [WIDTH-1:0]       opdata2_i;
    logic [2*WIDTH-1:0]     result_o;
    logic                   ready_o;
    logic                   busy_o;
    logic                   div_zero_o;

    modport master (
        output start_i, annul_i, op_div_i, op_signed_i, opdata1_i, opdata2_i,
        input  result_o, ready_o, busy_o, div_zero_o
    );

    modport slave (
        input  start_i, annul_i, op_div_i, op_signed_i, opdata1_i, opdata2_i,
        output result_o, ready_o, busy_o, div_zero_o
    );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit: restoring radix-2 divide and shift-add multiply sharing one
// WIDTH-cycle datapath, operating on magnitudes with a sign fix-up on the way into DONE.
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_iter_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int W2    = 2 * WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [W2-1:0]      result_q, result_d;
    logic               dz_q, dz_d;

    logic               op_div_q, op_div_d;
    logic               sgn_res_q, sgn_res_d;
    logic               sgn_rem_q, sgn_rem_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [WIDTH:0]     shifted;
    logic               trial_ge;
    logic [WIDTH:0]     msum;
    logic [WIDTH-1:0]   hi_step, lo_step;
    logic [W2-1:0]      res_fix;
    logic               s1, s2;

    function automatic logic [WIDTH-1:0] cneg_w(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [W2-1:0] cneg_2w(input logic [W2-1:0] v, input logic neg);
        return neg ? (~v + W2'(1)) : v;
    endfunction

    // One iteration step: divide shifts a dividend bit into the partial remainder and
    // subtracts when it fits; multiply adds the multiplicand into the high half and shifts right.
    always_comb begin
        shifted  = {hi_q, lo_q[WIDTH-1]};
        trial_ge = (shifted >= {1'b0, opnd_q});
        msum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        if (op_div_q) begin
            hi_step = trial_ge ? WIDTH'(shifted - {1'b0, opnd_q}) : shifted[WIDTH-1:0];
            lo_step = {lo_q[WIDTH-2:0], trial_ge};
        end else begin
            hi_step = msum[WIDTH:1];
            lo_step = {msum[0], lo_q[WIDTH-1:1]};
        end
        res_fix = op_div_q ? {cneg_w(hi_step, sgn_rem_q), cneg_w(lo_step, sgn_res_q)}
                           : cneg_2w({hi_step, lo_step}, sgn_res_q);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        dz_d      = dz_q;
        op_div_d  = op_div_q;
        sgn_res_d = sgn_res_q;
        sgn_rem_d = sgn_rem_q;
        opnd_d    = opnd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        s1        = bus.op_signed_i & bus.opdata1_i[WIDTH-1];
        s2        = bus.op_signed_i & bus.opdata2_i[WIDTH-1];
        unique case (state_q)
            S_IDLE: begin
                if (bus.start_i && !bus.annul_i) begin
                    op_div_d  = bus.op_div_i;
                    sgn_res_d = s1 ^ s2;
                    sgn_rem_d = s1;
                    cnt_d     = '0;
                    dz_d      = 1'b0;
                    hi_d      = '0;
                    if (bus.op_div_i && (bus.opdata2_i == '0)) begin
                        state_d  = S_DONE;
                        result_d = {bus.opdata1_i, {WIDTH{1'b1}}};
                        dz_d     = 1'b1;
                    end else if (bus.op_div_i) begin
                        state_d = S_CALC;
                        opnd_d  = cneg_w(bus.opdata2_i, s2);
                        lo_d    = cneg_w(bus.opdata1_i, s1);
                    end else begin
                        state_d = S_CALC;
                        opnd_d  = cneg_w(bus.opdata1_i, s1);
                        lo_d    = cneg_w(bus.opdata2_i, s2);
                    end
                end
            end
            S_CALC: begin
                if (bus.annul_i) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    hi_d = hi_step;
                    lo_d = lo_step;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d  = S_DONE;
                        cnt_d    = '0;
                        result_d = res_fix;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            dz_q     <= dz_d;
        end
    end

    // Operand/iteration registers are only meaningful after an accept, so they carry no reset.
    always_ff @(posedge clk) begin
        op_div_q  <= op_div_d;
        sgn_res_q <= sgn_res_d;
        sgn_rem_q <= sgn_rem_d;
        opnd_q    <= opnd_d;
        hi_q      <= hi_d;
        lo_q      <= lo_d;
    end

    assign bus.result_o   = result_q;
    assign bus.ready_o    = (state_q == S_DONE) && !bus.annul_i;
    assign bus.busy_o     = (state_q != S_IDLE);
    assign bus.div_zero_o = bus.ready_o && dz_q;
endmodule
